// File: rtl/tdc_multi_core.sv
// rtl/tdc_multi_core.sv - multi-channel pulse-width TDC packing words into a FWFT FIFO
// Optional dropped-pulse counter compiled in with TDC_MULTI_LOST_CNT_EN.
module tdc_multi_core #(
   parameter int         CHANNELS        = 4,
   parameter int         DEPTH           = 16,
   parameter logic [3:0] DATA_IDENTIFIER = 4'b0100
) (
   input  logic                BUS_CLK,
   input  logic                BUS_RST_N,
   input  logic                EN,
   input  logic [CHANNELS-1:0] TDC_IN,
   input  logic [15:0]         TIMESTAMP,
   input  logic                FIFO_READ,
   output logic                FIFO_EMPTY,
   output logic                FIFO_FULL,
   output logic [31:0]         FIFO_DATA,
   output logic [7:0]          LOST_CNT
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t              state_q [CHANNELS];
   logic [11:0]         width_q [CHANNELS];
   logic [11:0]         ts_q    [CHANNELS];
   logic [CHANNELS-1:0] tdc_q;
   logic                armed_q;
   logic [4:0]          ptr_q, ptr_d;
   logic [CHANNELS-1:0] rise, fall, done, gnt;
   logic                gnt_valid;
   logic [31:0]         gnt_word;
   logic [31:0]         mem_q [DEPTH];
   logic [AW-1:0]       wr_q, rd_q;
   logic [AW:0]         cnt_q;
   logic                push, pop;
   logic                unused_ts;

   assign unused_ts = ^TIMESTAMP[15:12];

   // armed_q masks the first cycle after reset so an input already high is not seen as a rise
   always_comb begin
      rise = '0;
      fall = '0;
      done = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         rise[c] = armed_q & TDC_IN[c] & ~tdc_q[c];
         fall[c] = ~TDC_IN[c] & tdc_q[c];
         done[c] = (state_q[c] == DONE);
      end
   end

   // Two passes over the channels: indices at/after ptr_q first, then wrap to the rest
   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      gnt_word  = '0;
      ptr_d     = ptr_q;
      if (!FIFO_FULL) begin
         for (int k = 0; k < 2 * CHANNELS; k++) begin
            if (!gnt_valid && done[k % CHANNELS] && ((k >= CHANNELS) || (5'(k) >= ptr_q))) begin
               gnt[k % CHANNELS] = 1'b1;
               gnt_valid         = 1'b1;
               gnt_word          = {DATA_IDENTIFIER, 4'(k % CHANNELS),
                                    ts_q[k % CHANNELS], width_q[k % CHANNELS]};
               ptr_d             = ((k % CHANNELS) == CHANNELS - 1) ? 5'd0 : 5'((k % CHANNELS) + 1);
            end
         end
      end
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         tdc_q   <= '0;
         armed_q <= 1'b0;
         ptr_q   <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            state_q[c] <= IDLE;
            width_q[c] <= '0;
            ts_q[c]    <= '0;
         end
      end else begin
         tdc_q   <= TDC_IN;
         armed_q <= 1'b1;
         ptr_q   <= ptr_d;
         for (int c = 0; c < CHANNELS; c++) begin
            case (state_q[c])
               IDLE: begin
                  if (rise[c] && EN) begin
                     state_q[c] <= COUNT;
                     width_q[c] <= 12'd1;
                     ts_q[c]    <= TIMESTAMP[11:0];
                  end
               end
               COUNT: begin
                  if (!EN) begin
                     state_q[c] <= IDLE;
                  end else if (fall[c]) begin
                     state_q[c] <= DONE;
                  end else if (TDC_IN[c] && (width_q[c] != 12'hFFF)) begin
                     width_q[c] <= width_q[c] + 12'd1;
                  end
               end
               DONE: begin
                  if (gnt[c]) state_q[c] <= IDLE;
               end
               default: state_q[c] <= IDLE;
            endcase
         end
      end
   end

   assign push       = gnt_valid;
   assign pop        = FIFO_READ & ~FIFO_EMPTY;
   assign FIFO_EMPTY = (cnt_q == '0);
   assign FIFO_FULL  = (cnt_q == (AW+1)'(DEPTH));
   assign FIFO_DATA  = FIFO_EMPTY ? 32'd0 : mem_q[rd_q];

   always_ff @(posedge BUS_CLK) begin
      if (push) mem_q[wr_q] <= gnt_word;
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

`ifdef TDC_MULTI_LOST_CNT_EN
   logic [7:0] lost_q;
   logic [9:0] lost_sum;

   // A rise on a channel still holding an unsent word cannot be measured
   always_comb begin
      lost_sum = {2'b00, lost_q};
      for (int c = 0; c < CHANNELS; c++) begin
         lost_sum = lost_sum + 10'(rise[c] & done[c]);
      end
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) lost_q <= '0;
      else            lost_q <= (lost_sum > 10'd255) ? 8'hFF : lost_sum[7:0];
   end

   assign LOST_CNT = lost_q;
`else
   assign LOST_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_tdc_multi_core.sv
// tb/tb_tdc_multi_core.sv - scoreboard bench for tdc_multi_core (DEPTH=4 instance)
`timescale 1ns/1ps
module tb_tdc_multi_core;
`ifdef TDC_MULTI_LOST_CNT_EN
   localparam logic [31:0] LOST_EXP = 32'd1;
`else
   localparam logic [31:0] LOST_EXP = 32'd0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  tdc_in = 4'd0;
   logic [15:0] ts = 16'd0;
   logic        fifo_read = 1'b0;
   logic        fifo_empty, fifo_full;
   logic [31:0] fifo_data;
   logic [7:0]  lost_cnt;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q [$];
   bit          auto_read = 1'b0;

   always #5 clk = ~clk;

   tdc_multi_core #(.CHANNELS(4), .DEPTH(4), .DATA_IDENTIFIER(4'b0100)) dut (
      .BUS_CLK(clk), .BUS_RST_N(rst_n), .EN(en), .TDC_IN(tdc_in), .TIMESTAMP(ts),
      .FIFO_READ(fifo_read), .FIFO_EMPTY(fifo_empty), .FIFO_FULL(fifo_full),
      .FIFO_DATA(fifo_data), .LOST_CNT(lost_cnt));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || !fifo_empty) && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || !fifo_empty) begin
         failures++;
         $display("FAIL %s drain timeout pending=%0d empty=%0b required pending=0 empty=1",
                  name, exp_q.size(), fifo_empty);
      end
   endtask

   // Monitor: pops the head word whenever reading is enabled and the FIFO presents data
   always @(negedge clk) begin
      if (auto_read && !fifo_empty) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=0x%08h required=none", fifo_data);
         end else begin
            chk("word", fifo_data, exp_q.pop_front());
         end
         fifo_read = 1'b1;
      end else begin
         fifo_read = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("rst_empty", fifo_empty, 1);
      chk("rst_full", fifo_full, 0);
      chk("rst_lost", lost_cnt, 0);
      chk("rst_data", fifo_data, 0);
      rst_n = 1'b1;
      repeat (2) tick();
      en = 1'b1;

      // simultaneous burst, round-robin from reset pointer
      auto_read = 1'b1;
      ts = 16'h0100;
      tdc_in = 4'hF;
      exp_q.push_back(32'h40100003); exp_q.push_back(32'h41100003);
      exp_q.push_back(32'h42100003); exp_q.push_back(32'h43100003);
      repeat (3) tick();
      tdc_in = 4'h0;
      wait_drain("burst1");

      ts = 16'h0200;
      tdc_in = 4'hF;
      exp_q.push_back(32'h40200005); exp_q.push_back(32'h41200005);
      exp_q.push_back(32'h42200005); exp_q.push_back(32'h43200005);
      repeat (5) tick();
      tdc_in = 4'h0;
      wait_drain("burst2");

      // single pulse, latency from fall to non-empty
      auto_read = 1'b0;
      ts = 16'h1234;
      tdc_in[2] = 1'b1;
      repeat (10) tick();
      tdc_in[2] = 1'b0;
      tick();
      chk("empty_at_fall", fifo_empty, 1);
      tick();
      chk("empty_lat2", fifo_empty, 0);
      exp_q.push_back(32'h4223400A);
      auto_read = 1'b1;
      wait_drain("ch2_pulse");

      // saturating width
      ts = 16'h0ABC;
      tdc_in[1] = 1'b1;
      repeat (5000) tick();
      tdc_in[1] = 1'b0;
      exp_q.push_back(32'h41ABCFFF);
      wait_drain("sat_pulse");

      // EN abort mid-pulse
      ts = 16'h0555;
      tdc_in[3] = 1'b1;
      repeat (10) tick();
      en = 1'b0;
      tick();
      en = 1'b1;
      repeat (10) tick();
      tdc_in[3] = 1'b0;
      repeat (10) tick();
      chk("en_abort_empty", fifo_empty, 1);

      // fill DEPTH=4, hold two channels in DONE, drop a rise
      auto_read = 1'b0;
      ts = 16'h0300;
      tdc_in = 4'hF;
      exp_q.push_back(32'h42300002); exp_q.push_back(32'h43300002);
      exp_q.push_back(32'h40300002); exp_q.push_back(32'h41300002);
      repeat (2) tick();
      tdc_in = 4'h0;
      repeat (6) tick();
      chk("full_after4", fifo_full, 1);
      ts = 16'h0310;
      tdc_in = 4'b0011;
      exp_q.push_back(32'h40310003); exp_q.push_back(32'h41310003);
      repeat (3) tick();
      tdc_in = 4'h0;
      repeat (4) tick();
      chk("full_hold", fifo_full, 1);
      chk("head_while_full", fifo_data, 32'h42300002);
      tdc_in[0] = 1'b1;
      repeat (2) tick();
      tdc_in[0] = 1'b0;
      tick();
      chk("lost_cnt", lost_cnt, LOST_EXP);
      auto_read = 1'b1;
      wait_drain("full_drain");
      chk("lost_cnt_after", lost_cnt, LOST_EXP);

      // reset with stored words and a channel counting
      auto_read = 1'b0;
      ts = 16'h0400;
      tdc_in = 4'b1110;
      repeat (2) tick();
      tdc_in = 4'h0;
      repeat (6) tick();
      chk("stored_nonempty", fifo_empty, 0);
      tdc_in[0] = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("async_rst_empty", fifo_empty, 1);
      chk("async_rst_lost", lost_cnt, 0);
      chk("async_rst_data", fifo_data, 0);
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      tdc_in[0] = 1'b0;
      repeat (10) tick();
      chk("no_word_after_rst", fifo_empty, 1);
      auto_read = 1'b1;
      repeat (5) tick();
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tdc_multi_core.md
TDC_MULTI_CORE -- requirements
Module: tdc_multi_core

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of TDC inputs; legal range 1..16.
REQ-002 SHALL have parameter DEPTH, default 16, output FIFO entries; power of two, 4..256.
REQ-003 SHALL have parameter DATA_IDENTIFIER, default 4'b0100, placed in word bits [31:28].
REQ-004 SHALL have port BUS_CLK  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port BUS_RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port EN  input  1  global measurement enable.
REQ-007 SHALL have port TDC_IN  input  CHANNELS  pulse inputs, already synchronous to BUS_CLK.
REQ-008 SHALL have port TIMESTAMP  input  16  free-running time base.
REQ-009 SHALL have port FIFO_READ  input  1  pop request.
REQ-010 SHALL have port FIFO_EMPTY  output  1  high when FIFO holds no word.
REQ-011 SHALL have port FIFO_FULL  output  1  high when FIFO holds DEPTH words.
REQ-012 SHALL have port FIFO_DATA  output  32  head word, first-word-fall-through.
REQ-013 SHALL have port LOST_CNT  output  8  count of dropped pulses.

Function
REQ-014 Each channel SHALL register TDC_IN; rise = TDC_IN=1 and previous=0; fall = TDC_IN=0 and previous=1.
REQ-015 Each channel SHALL run FSM IDLE/COUNT/DONE; IDLE->COUNT on rise with EN=1, loading width=1 and TIMESTAMP[11:0].
REQ-016 In COUNT the channel SHALL increment width each cycle TDC_IN=1, saturating at 4095, and go to DONE on fall.
REQ-017 Width SHALL equal the number of cycles TDC_IN was sampled high (pulse of W cycles gives W, W>=4095 gives 4095).
REQ-018 EN=0 in COUNT SHALL abort the channel to IDLE with no word produced; EN=0 in DONE SHALL NOT cancel the pending word.
REQ-019 A rise seen while a channel is in COUNT-exit or DONE (including the grant cycle) SHALL be dropped and counted in LOST_CNT.
REQ-020 Arbiter SHALL grant at most one DONE channel per cycle, round-robin starting after the last granted index, only when FIFO_FULL=0.
REQ-021 Granted channel SHALL write word {DATA_IDENTIFIER, chan[3:0], ts[11:0], width[11:0]} into the FIFO at the end of the grant cycle and return to IDLE.
REQ-022 Earliest grant SHALL be the cycle after fall detection; FIFO_EMPTY SHALL fall the cycle after the write (fall to FIFO_EMPTY=0 latency 2 cycles).
REQ-023 FIFO_READ with FIFO_EMPTY=1 SHALL be ignored; pop and write in the same cycle SHALL both take effect, count unchanged.
REQ-024 FIFO_FULL SHALL block grants; DONE channels SHALL hold their word until space exists; no word SHALL be overwritten or lost.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; FIFO_DATA SHALL be undefined only while FIFO_EMPTY=1.
REQ-026 LOST_CNT SHALL increment by the number of simultaneously dropped rises, saturating at 255.

Reset
REQ-027 BUS_RST_N=0 SHALL immediately force all channels to IDLE, input history to 0, arbiter pointer to 0, FIFO empty.
REQ-028 Reset values SHALL be FIFO_EMPTY=1, FIFO_FULL=0, LOST_CNT=0, FIFO_DATA=0.
REQ-029 Reset mid-measurement SHALL discard all in-flight and stored words; a TDC_IN already high at release SHALL NOT produce a rise.

Configuration
REQ-030 Macro TDC_MULTI_LOST_CNT_EN defined SHALL compile in the LOST_CNT counter per REQ-019/REQ-026.
REQ-031 Without TDC_MULTI_LOST_CNT_EN, LOST_CNT SHALL be constant 0 and dropped rises SHALL be silently ignored; all other behaviour identical.

Verification
REQ-032 Ch2 high 10 cycles, EN=1, TIMESTAMP=0x1234 at rise -> one word 0x4223400A, FIFO_EMPTY low 2 cycles after fall.
REQ-033 Ch0..3 fall in the same cycle -> four words in order ch0,1,2,3 on consecutive cycles; next simultaneous burst starts after last grant.
REQ-034 DEPTH=4, no reads, 6 pulses -> FIFO_FULL=1 with 4 words, 2 channels held in DONE; pop 2 -> remaining 2 words written, no loss.
REQ-035 Ch1 pulse 5000 cycles -> width field 4095; EN dropped during a 20-cycle pulse -> no word.
REQ-036 With TDC_MULTI_LOST_CNT_EN, second rise on ch0 while ch0 in DONE under FIFO_FULL -> LOST_CNT=1; without macro -> LOST_CNT=0.
REQ-037 BUS_RST_N low for 1 cycle with 3 stored words and ch0 counting -> FIFO_EMPTY=1, LOST_CNT=0, no word from ch0 after release.
